ldw_if_id_stage: RTL and testbench

- PC register plus IF/ID pipeline latch for the five-stage ldw CPU.
- Holds the architectural fetch PC that drives the IF stage (pc, which IF uses to form pc4, npc and the IMem address).
- Captures IF outputs (pc4, ins) into the ID-side register on each rising clock edge.
- Applies hazard-unit stall, branch/jump flush, and a halt-drain sequence; also keeps a stall-cycle performance counter.

---
 rtl/ldw_pkg.sv | 16 +
 rtl/ldw_sat_counter.sv | 28 ++
 rtl/ldw_if_id_stage.sv | 134 +++++++++++++
 tb/tb_ldw_if_id_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ldw_pkg.sv
// ldw_pkg: definitions shared by the ldw IF/ID stage and its helpers.
//   ldw_state_e  - fetch-control FSM state encoding
//   LDW_NOP_INS  - bubble instruction word (sll $0,$0,0)
//   LDW_SAT_MAX  - saturation ceiling for 32-bit performance counters
package ldw_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ldw_state_e;

    localparam logic [31:0] LDW_NOP_INS = 32'h0000_0000;
    localparam logic [31:0] LDW_SAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/ldw_sat_counter.sv
// ldw_sat_counter: 32-bit up-counter with synchronous clear and saturation.
// Ports:
//   clk   - clock, rising edge
//   clr   - synchronous clear (highest priority)
//   en    - increment enable; the count sticks once it reaches LDW_SAT_MAX
//   count - current count
module ldw_sat_counter
    import ldw_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != LDW_SAT_MAX)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ldw_if_id_stage.sv
// ldw_if_id_stage: fetch PC register and IF/ID pipeline latch for the ldw CPU.
// Handles hazard stall, branch/jump flush and a halt-drain sequence, and
// counts stalled cycles.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   npc, if_pc4,
//   if_ins            - next PC, pc+4 and fetched instruction from IF
//   stall, flush,
//   halt_req          - hazard stall, taken branch/jump, halt request from ID
//   pc                - fetch PC to IF
//   id_pc4, id_ins,
//   id_valid          - IF/ID latch contents for ID (id_valid=0 is a bubble)
//   halted            - core has fully halted
//   stall_cnt         - cycles spent stalled in RUN (saturating)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal fetch; stall > halt_req > flush > advance
// ST_DRAIN  | halt accepted; pc frozen, bubbles fed while EXE/MEM/WB retire
// ST_HALTED | fully stopped; only rst leaves
module ldw_if_id_stage
    import ldw_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INS      = LDW_NOP_INS,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic [31:0] if_pc4,
    input  logic [31:0] if_ins,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_ins,
    output logic        id_valid,
    output logic        halted,
    output logic [31:0] stall_cnt
);

    // The halt-accept edge is the first of the DRAIN_CYCLES edges, so the
    // counter starts one short of the total.
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    ldw_state_e  state_q, state_d;
    logic [7:0]  drain_q, drain_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_ins_q, id_ins_d;
    logic        id_valid_q, id_valid_d;
    logic        stall_cnt_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            drain_q    <= '0;
            pc_q       <= RESET_PC;
            id_pc4_q   <= '0;
            id_ins_q   <= NOP_INS;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            pc_q       <= pc_d;
            id_pc4_q   <= id_pc4_d;
            id_ins_q   <= id_ins_d;
            id_valid_q <= id_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        pc_d         = pc_q;
        id_pc4_d     = id_pc4_q;
        id_ins_d     = id_ins_q;
        id_valid_d   = id_valid_q;
        stall_cnt_en = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    // ID instruction unresolved: flush/halt_req not trusted yet
                    stall_cnt_en = 1'b1;
                end else if (halt_req) begin
                    id_pc4_d   = '0;
                    id_ins_d   = NOP_INS;
                    id_valid_d = 1'b0;
                    drain_d    = DRAIN_LOAD;
                    state_d    = (DRAIN_CYCLES > 1) ? ST_DRAIN : ST_HALTED;
                end else if (flush) begin
                    pc_d       = npc;
                    id_pc4_d   = '0;
                    id_ins_d   = NOP_INS;
                    id_valid_d = 1'b0;
                end else begin
                    pc_d       = npc;
                    id_pc4_d   = if_pc4;
                    id_ins_d   = if_ins;
                    id_valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - 8'd1;
                if (drain_q <= 8'd1) begin
                    drain_d = '0;
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    ldw_sat_counter u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (stall_cnt_en),
        .count (stall_cnt)
    );

    assign pc       = pc_q;
    assign id_pc4   = id_pc4_q;
    assign id_ins   = id_ins_q;
    assign id_valid = id_valid_q;
    assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ldw_if_id_stage.sv
// tb_ldw_if_id_stage: directed test-plan sequence followed by random
// stall/flush/halt/reset traffic, all checked against a behavioural model.
module tb_ldw_if_id_stage;

    localparam int DRAIN_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc, if_pc4, if_ins;
    logic        stall, flush, halt_req;
    logic [31:0] pc, id_pc4, id_ins, stall_cnt;
    logic        id_valid, halted;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    logic [31:0] m_pc, m_pc4, m_ins, m_cnt;
    logic        m_valid, m_halted, m_draining;
    int          m_left;

    always #5 clk = ~clk;

    ldw_if_id_stage #(
        .RESET_PC     (32'h0000_0000),
        .NOP_INS      (32'h0000_0000),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .npc       (npc),
        .if_pc4    (if_pc4),
        .if_ins    (if_ins),
        .stall     (stall),
        .flush     (flush),
        .halt_req  (halt_req),
        .pc        (pc),
        .id_pc4    (id_pc4),
        .id_ins    (id_ins),
        .id_valid  (id_valid),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins_at(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h2001_0005;
            32'h4:   return 32'h2002_0007;
            32'h40:  return 32'h2003_0040;
            default: return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic f, input logic h,
                              input logic [31:0] n, input logic [31:0] p4, input logic [31:0] ins);
        if (r) begin
            m_pc = 0; m_pc4 = 0; m_ins = 0; m_valid = 0;
            m_halted = 0; m_draining = 0; m_left = 0; m_cnt = 0;
        end else if (m_halted) begin
        end else if (m_draining) begin
            m_left--;
            if (m_left == 0) begin
                m_draining = 0;
                m_halted   = 1;
            end
        end else if (s) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (h) begin
            m_pc4 = 0; m_ins = 0; m_valid = 0;
            m_left = DRAIN_CYCLES - 1;
            if (m_left == 0) m_halted = 1;
            else m_draining = 1;
        end else if (f) begin
            m_pc = n; m_pc4 = 0; m_ins = 0; m_valid = 0;
        end else begin
            m_pc = n; m_pc4 = p4; m_ins = ins; m_valid = 1;
        end
    endtask

    // One clock: drive IF from the model's fetch PC, clock, then compare.
    task automatic cyc(input logic r, input logic s, input logic f, input logic h,
                       input logic [31:0] target);
        rst      = r;
        stall    = s;
        flush    = f;
        halt_req = h;
        if_pc4   = m_pc + 32'd4;
        if_ins   = ins_at(m_pc);
        npc      = f ? target : m_pc + 32'd4;
        @(posedge clk);
        model_edge(r, s, f, h, npc, if_pc4, if_ins);
        #1;
        chk("pc",        pc,               m_pc);
        chk("id_pc4",    id_pc4,           m_pc4);
        chk("id_ins",    id_ins,           m_ins);
        chk("id_valid",  {31'd0, id_valid}, {31'd0, m_valid});
        chk("halted",    {31'd0, halted},  {31'd0, m_halted});
        chk("stall_cnt", stall_cnt,        m_cnt);
    endtask

    initial begin
        m_pc = 0; m_pc4 = 0; m_ins = 0; m_valid = 0;
        m_halted = 0; m_draining = 0; m_left = 0; m_cnt = 0;
        rst = 1; stall = 0; flush = 0; halt_req = 0;
        npc = 0; if_pc4 = 0; if_ins = 0;

        // reset then free-run
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("tp_rst_pc", pc, 32'h0);
        chk("tp_rst_valid", {31'd0, id_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("tp_run_ins0", id_ins, 32'h2001_0005);
        chk("tp_run_pc4", id_pc4, 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("tp_run_ins1", id_ins, 32'h2002_0007);
        chk("tp_run_pc8", pc, 32'h8);

        // load-use stall at pc 8
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("tp_stall_pc", pc, 32'h8);
        chk("tp_stall_cnt", stall_cnt, 32'd2);
        cyc(0, 0, 0, 0, 0);
        chk("tp_resume_pc", pc, 32'hC);

        // taken branch at 0xC
        cyc(0, 0, 1, 0, 32'h40);
        chk("tp_br_pc", pc, 32'h40);
        chk("tp_br_valid", {31'd0, id_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("tp_br_ins", id_ins, 32'h2003_0040);

        // stall with flush: flush ignored, then honoured
        cyc(0, 1, 1, 0, 32'h80);
        chk("tp_sf_hold", pc, 32'h44);
        cyc(0, 0, 1, 0, 32'h80);
        chk("tp_sf_pc", pc, 32'h80);

        // halt drain at 0x20 with ignored pulses
        cyc(0, 0, 1, 0, 32'h20);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 32'h100);
        chk("tp_drain_halted", {31'd0, halted}, 32'd0);
        cyc(0, 1, 0, 1, 0);
        chk("tp_halted", {31'd0, halted}, 32'd1);
        chk("tp_halt_pc", pc, 32'h20);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 32'h200);
        chk("tp_halt_cnt", stall_cnt, 32'd3);

        // reset mid-drain
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        chk("tp_rd_pc", pc, 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        chk("tp_rd_run", pc, 32'hC);

        // saturation from a preloaded counter
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.count_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        chk("tp_sat", stall_cnt, 32'hFFFF_FFFF);

        // random traffic
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic r, s, f, h;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 6) == 0);
            h = ($urandom_range(0, 99) == 0);
            cyc(r, s, f, h, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
